// File: rtl/lcd12864_gfx_ctrl.sv
// ST7920 128x64 graphic-mode controller (8-bit parallel, write-only).
// Runs power-on wait, init and clear once, then streams a framebuffer to GDRAM.
module lcd12864_gfx_ctrl #(
    parameter int CLK_DIV    = 1800,
    parameter int POR_WAIT   = 2000000,
    parameter int CLEAR_WAIT = 80000,
    parameter int ROWS       = 64,
    parameter int ROW_BYTES  = 16,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_data,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_en,
    output logic [7:0]        lcd_dat
);
    localparam int SLOT_LEN = 2 * CLK_DIV;
    localparam int SLOT_W   = $clog2(SLOT_LEN);
    localparam int ROW_W    = $clog2(ROWS);
    localparam int COL_W    = $clog2(ROW_BYTES);

    typedef enum logic [3:0] {
        S_POR, S_FUNC, S_DISP, S_CLR, S_CLR_WAIT, S_EXT, S_GFX,
        S_IDLE, S_SET_Y, S_SET_X, S_DATA, S_FIN
    } state_t;

    state_t            state, next_state;
    logic [SLOT_W-1:0] slot_cnt;
    logic [31:0]       wait_cnt;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  row_y;
    logic [COL_W-1:0]  col;
    logic [7:0]        data_q;
    logic              init_done;
    logic              in_slot, slot_end, last_col, last_row, upper_half;
    logic              por_done, clr_done;

    assign in_slot    = state inside {S_FUNC, S_DISP, S_CLR, S_EXT, S_GFX,
                                      S_SET_Y, S_SET_X, S_DATA};
    assign slot_end   = in_slot && (slot_cnt == SLOT_W'(SLOT_LEN - 1));
    assign last_col   = (col == COL_W'(ROW_BYTES - 1));
    assign last_row   = (row == ROW_W'(ROWS - 1));
    assign upper_half = (row >= ROW_W'(ROWS / 2));
    assign row_y      = upper_half ? row - ROW_W'(ROWS / 2) : row;
    assign por_done   = (wait_cnt + 32'd1 >= 32'(POR_WAIT));
    assign clr_done   = (wait_cnt + 32'd1 >= 32'(CLEAR_WAIT));
    assign lcd_rw     = 1'b0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) state <= S_POR;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_POR:      if (por_done) next_state = S_FUNC;
            S_FUNC:     if (slot_end) next_state = S_DISP;
            S_DISP:     if (slot_end) next_state = S_CLR;
            S_CLR:      if (slot_end) next_state = S_CLR_WAIT;
            S_CLR_WAIT: if (clr_done) next_state = S_EXT;
            S_EXT:      if (slot_end) next_state = S_GFX;
            S_GFX:      if (slot_end) next_state = S_IDLE;
            S_IDLE:     if (start && init_done) next_state = S_SET_Y;
            S_SET_Y:    if (slot_end) next_state = S_SET_X;
            S_SET_X:    if (slot_end) next_state = S_DATA;
            S_DATA:     if (slot_end && last_col) next_state = last_row ? S_FIN : S_SET_Y;
            S_FIN:      next_state = continuous ? S_SET_Y : S_IDLE;
            default:    next_state = S_POR;
        endcase
    end

    // fb_addr runs one slot ahead of the data on the bus; it is held on the
    // second-to-last column so it never passes ROWS*ROW_BYTES-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt  <= '0;
            wait_cnt  <= '0;
            row       <= '0;
            col       <= '0;
            fb_addr   <= '0;
            data_q    <= '0;
            init_done <= 1'b0;
        end else begin
            slot_cnt <= (in_slot && !slot_end) ? slot_cnt + 1'b1 : '0;
            wait_cnt <= ((state == S_POR && !por_done) ||
                         (state == S_CLR_WAIT && !clr_done)) ? wait_cnt + 32'd1 : '0;
            if (state == S_GFX && slot_end)
                init_done <= 1'b1;
            if ((state == S_SET_X || state == S_DATA) && slot_end)
                data_q <= fb_data;
            case (state)
                S_IDLE, S_FIN: begin
                    row     <= '0;
                    col     <= '0;
                    fb_addr <= '0;
                end
                S_SET_X: if (slot_end) begin
                    col     <= '0;
                    fb_addr <= fb_addr + 1'b1;
                end
                S_DATA: if (slot_end) begin
                    col <= col + 1'b1;
                    if (last_col) begin
                        if (!last_row) begin
                            row     <= row + 1'b1;
                            fb_addr <= fb_addr + 1'b1;
                        end
                    end else if (col != COL_W'(ROW_BYTES - 2)) begin
                        fb_addr <= fb_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        lcd_rs  = 1'b0;
        lcd_dat = 8'h00;
        busy    = (state != S_IDLE);
        done    = (state == S_FIN);
        lcd_en  = in_slot && (slot_cnt != '0) && (slot_cnt <= SLOT_W'(CLK_DIV));
        case (state)
            S_FUNC:  lcd_dat = 8'h30;
            S_DISP:  lcd_dat = 8'h0C;
            S_CLR:   lcd_dat = 8'h01;
            S_EXT:   lcd_dat = 8'h34;
            S_GFX:   lcd_dat = 8'h36;
            S_SET_Y: lcd_dat = 8'h80 | 8'(row_y);
            S_SET_X: lcd_dat = upper_half ? 8'h88 : 8'h80;
            S_DATA: begin
                lcd_rs  = 1'b1;
                lcd_dat = data_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lcd12864_gfx_ctrl.sv
// Self-checking bench: a write-transaction model (expected rs/dat, gap between
// en falls, fb_addr, done/busy timing) compared against the LCD pins every cycle.
module tb_lcd12864_gfx_ctrl;
    localparam int CLK_DIV      = 2;
    localparam int POR_WAIT     = 10;
    localparam int CLEAR_WAIT   = 20;
    localparam int ROWS         = 64;
    localparam int ROW_BYTES    = 16;
    localparam int ADDR_W       = 10;
    localparam int FB_SIZE      = ROWS * ROW_BYTES;
    localparam int FRAME_CYCLES = ROWS * (2 + ROW_BYTES) * 2 * CLK_DIV;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic              busy, done;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic              lcd_rs, lcd_rw, lcd_en;
    logic [7:0]        lcd_dat;

    lcd12864_gfx_ctrl #(
        .CLK_DIV(CLK_DIV), .POR_WAIT(POR_WAIT), .CLEAR_WAIT(CLEAR_WAIT),
        .ROWS(ROWS), .ROW_BYTES(ROW_BYTES), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .busy(busy), .done(done), .fb_addr(fb_addr), .fb_data(fb_data),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dat(lcd_dat)
    );

    always #5 clk = ~clk;

    logic [7:0] fb_mem [FB_SIZE];
    always @(posedge clk) fb_data <= fb_mem[fb_addr];

    // One entry per expected LCD write; gap = cycles since the previous en fall.
    typedef struct {
        logic       rs;
        logic [7:0] dat;
        int         addr;
        int         gap;
        bit         last;
        bit         cont;
    } wr_t;
    wr_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pattern(input int sel, input int i);
        logic [31:0] v;
        v = i;
        case (sel)
            0:       return v[7:0];
            1:       return 8'((v * 37) ^ (v >> 3));
            default: return 8'(~v + (v >> 4) * 5);
        endcase
    endfunction

    task automatic fill_fb(input int sel);
        for (int i = 0; i < FB_SIZE; i++) fb_mem[i] = pattern(sel, i);
    endtask

    task automatic push_wr(input logic rs, input logic [7:0] dat, input int addr,
                           input int gap, input bit last, input bit cont);
        wr_t w;
        w.rs = rs; w.dat = dat; w.addr = addr; w.gap = gap; w.last = last; w.cont = cont;
        exp_q.push_back(w);
    endtask

    // First command: POR_WAIT idle cycles, setup cycle, CLK_DIV high cycles.
    task automatic push_init();
        push_wr(1'b0, 8'h30, -1, POR_WAIT + CLK_DIV + 1, 1'b0, 1'b0);
        push_wr(1'b0, 8'h0C, -1, 2 * CLK_DIV, 1'b0, 1'b0);
        push_wr(1'b0, 8'h01, -1, 2 * CLK_DIV, 1'b0, 1'b0);
        push_wr(1'b0, 8'h34, -1, 2 * CLK_DIV + CLEAR_WAIT, 1'b0, 1'b0);
        push_wr(1'b0, 8'h36, -1, 2 * CLK_DIV, 1'b0, 1'b0);
    endtask

    task automatic push_frame(input bit cont_next, input int first_gap);
        for (int r = 0; r < ROWS; r++) begin
            int base;
            base = r * ROW_BYTES;
            push_wr(1'b0, 8'h80 | 8'(r % (ROWS / 2)), -1,
                    (r == 0) ? first_gap : 2 * CLK_DIV, 1'b0, 1'b0);
            push_wr(1'b0, (r < ROWS / 2) ? 8'h80 : 8'h88, base, 2 * CLK_DIV, 1'b0, 1'b0);
            for (int c = 0; c < ROW_BYTES; c++)
                push_wr(1'b1, fb_mem[base + c], (c < ROW_BYTES - 1) ? base + c + 1 : -1,
                        2 * CLK_DIV, (r == ROWS - 1) && (c == ROW_BYTES - 1), cont_next);
        end
    endtask

    // Compare process: sampled on the falling clock edge.
    int         cyc = 0;
    int         last_fall = 0;
    int         hi_cnt = 0;
    int         done_due = -1;
    int         busy_due = -1;
    logic       busy_exp = 1'b0;
    logic       en_q = 1'b0;
    logic       rs_q = 1'b0;
    logic [7:0] dat_q = 8'h00;
    logic       rise_rs = 1'b0;
    logic [7:0] rise_dat = 8'h00;
    wr_t        e;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            hi_cnt    = 0;
            done_due  = -1;
            busy_due  = -1;
            last_fall = cyc + 1;
        end else begin
            if (lcd_en && !en_q) begin
                check("setup_rs_dat", {lcd_rs, lcd_dat}, {rs_q, dat_q});
                rise_rs  = lcd_rs;
                rise_dat = lcd_dat;
                hi_cnt   = 1;
            end else if (lcd_en) begin
                hi_cnt++;
                check("hold_during_en", {lcd_rs, lcd_dat}, {rise_rs, rise_dat});
            end
            if (!lcd_en && en_q) begin
                check("hold_at_fall", {lcd_rs, lcd_dat}, {rise_rs, rise_dat});
                check("en_width", hi_cnt, CLK_DIV);
                check("busy_in_write", busy, 1'b1);
                check("rw_low", lcd_rw, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_rs", rise_rs, e.rs);
                    check("wr_dat", rise_dat, e.dat);
                    if (e.addr >= 0) check("fb_addr", fb_addr, e.addr);
                    if (e.gap >= 0) check("wr_gap", cyc - last_fall, e.gap);
                    if (e.last) begin
                        done_due = cyc + CLK_DIV - 1;
                        busy_exp = e.cont;
                    end
                end
                last_fall = cyc;
            end
            if (done || cyc == done_due) begin
                check("done_pulse", done, cyc == done_due);
                if (cyc == done_due) begin
                    busy_due = cyc + 1;
                    done_due = -1;
                end
            end
            if (cyc == busy_due) begin
                check("busy_after_done", busy, busy_exp);
                busy_due = -1;
            end
        end
        en_q  = lcd_en;
        rs_q  = lcd_rs;
        dat_q = lcd_dat;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_finished"}, n < budget, 1'b1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, n < budget, 1'b1);
    endtask

    initial begin
        #1;
        repeat (2) tick();
        check("rst_en", lcd_en, 1'b0);
        check("rst_rs", lcd_rs, 1'b0);
        check("rst_dat", lcd_dat, 8'h00);
        check("rst_addr", fb_addr, 0);
        check("rst_busy", busy, 1'b1);
        check("rst_done", done, 1'b0);

        // init sequence after reset
        push_init();
        check("model_clr_cmd", exp_q[2].dat, 8'h01);
        check("model_clr_gap", exp_q[3].gap, 24);
        rst = 1'b0;
        wait_idle("init", 500);
        check("idle_busy", busy, 1'b0);

        // one frame, fb[i] = i[7:0]
        fill_fb(0);
        push_frame(1'b0, -1);
        check("model_row1_sety", exp_q[18].dat, 8'h81);
        check("model_row0_last", exp_q[17].dat, 8'h0F);
        check("model_row32_sety", exp_q[576].dat, 8'h80);
        check("model_row32_setx", exp_q[577].dat, 8'h88);
        check("model_row32_addr", exp_q[577].addr, 512);
        check("model_row32_d0", exp_q[578].dat, 8'h00);
        check("model_row32_d15", exp_q[593].dat, 8'h0F);
        pulse_start();
        wait_idle("frame_pulse", FRAME_CYCLES + 100);
        repeat (20) tick();

        // start held through the frame: exactly one frame
        fill_fb(1);
        push_frame(1'b0, -1);
        start = 1'b1;
        wait_done("held", FRAME_CYCLES + 100);
        start = 1'b0;
        wait_idle("held", 50);
        repeat (40) tick();
        check("held_busy_low", busy, 1'b0);

        // continuous: two back-to-back frames, then stop
        fill_fb(2);
        continuous = 1'b1;
        push_frame(1'b1, -1);
        push_frame(1'b0, 2 * CLK_DIV + 1);
        pulse_start();
        wait_done("cont1", FRAME_CYCLES + 100);
        repeat (200) tick();
        continuous = 1'b0;
        wait_idle("cont2", FRAME_CYCLES + 100);
        repeat (40) tick();

        // reset in the middle of a data slot
        fill_fb(0);
        push_frame(1'b0, -1);
        pulse_start();
        begin
            int n;
            n = 0;
            while (!(lcd_en && lcd_rs) && n < 200) begin
                tick();
                n++;
            end
            check("data_slot_reached", n < 200, 1'b1);
        end
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("abort_en", lcd_en, 1'b0);
        check("abort_dat", lcd_dat, 8'h00);
        check("abort_rs", lcd_rs, 1'b0);
        check("abort_busy", busy, 1'b1);
        check("abort_addr", fb_addr, 0);
        tick();
        push_init();
        rst = 1'b0;
        wait_idle("reinit", 500);

        // a normal frame after re-init
        fill_fb(1);
        push_frame(1'b0, -1);
        pulse_start();
        wait_idle("frame_after_reinit", FRAME_CYCLES + 100);
        repeat (20) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
